// File: rtl/hilo_div_unit_if.sv
// hilo_div_unit_if
//   CPU-side bundle for the HI/LO divide unit.
//   master : pipeline side; drives divide requests and MTHI/MTLO writes,
//            observes req_ready/busy, the HI/LO registers and status pulses.
//   slave  : the divide unit itself.
//   Signals:
//     req_valid, req_signed, req_a, req_b   divide request (DIV / DIVU)
//     wr_hi, wr_lo, wr_data                  MTHI / MTLO writes
//     req_ready, busy                        accept / stall indications
//     hi, lo                                 remainder / quotient registers
//     done, div_by_zero, div_timeout         one-cycle status pulses
interface hilo_div_unit_if;
  logic        req_valid;
  logic        req_signed;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        wr_hi;
  logic        wr_lo;
  logic [31:0] wr_data;
  logic        req_ready;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        done;
  logic        div_by_zero;
  logic        div_timeout;

  modport master (
    output req_valid, req_signed, req_a, req_b, wr_hi, wr_lo, wr_data,
    input  req_ready, busy, hi, lo, done, div_by_zero, div_timeout
  );

  modport slave (
    input  req_valid, req_signed, req_a, req_b, wr_hi, wr_lo, wr_data,
    output req_ready, busy, hi, lo, done, div_by_zero, div_timeout
  );
endinterface

// File: rtl/hilo_div_unit.sv
// hilo_div_unit
//   Sequences a signed/unsigned 32-bit divide through an external unsigned
//   divider and holds the architectural HI (remainder) / LO (quotient)
//   registers. Signed operands are converted to magnitudes before the divider
//   and the results re-signed on the way back.
//   Ports:
//     clock, reset        rising-edge clock, synchronous active-high reset
//     bus (slave)         request, MTHI/MTLO writes, HI/LO and status
//     div_start           one-cycle start pulse to the divider
//     div_operand1/2      dividend / divisor magnitudes, held until next request
//     div_result          {remainder, quotient} from the divider
//     div_finish          divider completion level (may stay high when idle)
module hilo_div_unit (
  input  logic        clock,
  input  logic        reset,
  hilo_div_unit_if.slave bus,
  output logic        div_start,
  output logic [31:0] div_operand1,
  output logic [31:0] div_operand2,
  input  logic [63:0] div_result,
  input  logic        div_finish
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q;
  logic [5:0]  wait_cnt_q;
  logic        neg_q_q;
  logic        neg_r_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic [31:0] op1_q;
  logic [31:0] op2_q;
  logic        div_start_q;
  logic        done_q;
  logic        dbz_q;
  logic        timeout_q;

  logic [31:0] mag_a_d;
  logic [31:0] mag_b_d;
  logic [31:0] lo_d;
  logic [31:0] hi_d;

  // Magnitudes going to the divider and re-signed results coming back.
  // 0x80000000 maps to itself, which the unsigned divider handles correctly.
  always_comb begin
    mag_a_d = (bus.req_signed && bus.req_a[31]) ? (32'd0 - bus.req_a) : bus.req_a;
    mag_b_d = (bus.req_signed && bus.req_b[31]) ? (32'd0 - bus.req_b) : bus.req_b;
    lo_d    = neg_q_q ? (32'd0 - div_result[31:0])  : div_result[31:0];
    hi_d    = neg_r_q ? (32'd0 - div_result[63:32]) : div_result[63:32];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      wait_cnt_q  <= 6'd0;
      neg_q_q     <= 1'b0;
      neg_r_q     <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      op1_q       <= 32'd0;
      op2_q       <= 32'd0;
      div_start_q <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      div_start_q <= 1'b0;
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      timeout_q   <= 1'b0;

      // MTHI/MTLO first; a division result written below in the same cycle
      // overrides these because the later non-blocking assignment wins.
      if (bus.wr_hi) hi_q <= bus.wr_data;
      if (bus.wr_lo) lo_q <= bus.wr_data;

      case (state_q)
        IDLE: begin
          if (bus.req_valid) begin
            if (bus.req_b == 32'd0) begin
              // Zero divisor: skip the divider entirely, HI/LO untouched.
              done_q  <= 1'b1;
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              neg_q_q     <= bus.req_signed & (bus.req_a[31] ^ bus.req_b[31]);
              neg_r_q     <= bus.req_signed & bus.req_a[31];
              op1_q       <= mag_a_d;
              op2_q       <= mag_b_d;
              div_start_q <= 1'b1;
              state_q     <= START;
            end
          end
        end
        START: begin
          wait_cnt_q <= 6'd0;
          state_q    <= WAIT;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + 6'd1;
          // wait_cnt_q==0 is the first WAIT cycle; div_finish there can be
          // left over from the previous operation, so it is not trusted.
          if ((wait_cnt_q != 6'd0) && div_finish) begin
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (wait_cnt_q == 6'd62) begin
            // Counter reaches 63 at this edge with no finish seen.
            timeout_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = (state_q == IDLE);
  assign bus.busy        = (state_q != IDLE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.done        = done_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.div_timeout = timeout_q;
  assign div_start       = div_start_q;
  assign div_operand1    = op1_q;
  assign div_operand2    = op2_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
module tb_hilo_div_unit;

  logic        clock;
  logic        reset;
  logic        div_start;
  logic [31:0] div_operand1;
  logic [31:0] div_operand2;
  logic [63:0] div_result;
  logic        div_finish;

  hilo_div_unit_if bus ();

  hilo_div_unit dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus.slave),
    .div_start    (div_start),
    .div_operand1 (div_operand1),
    .div_operand2 (div_operand2),
    .div_result   (div_result),
    .div_finish   (div_finish)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Cycle counter and divider-start counter
  int cyc = 0;
  int start_cnt = 0;
  always @(posedge clock) begin
    cyc <= cyc + 1;
    if (div_start === 1'b1) start_cnt = start_cnt + 1;
  end

  // 32-step unsigned divider model: start seen at the end of cycle 1,
  // finish rises in cycle 34. finish is a level that stays high until the
  // second cycle after the next start, so the first WAIT cycle sees it stale.
  bit        hang = 1'b0;
  int        dcnt = 0;
  initial begin
    div_finish = 1'b0;
    div_result = 64'd0;
  end
  always @(posedge clock) begin
    if (div_start === 1'b1) begin
      dcnt <= 32;
      if (div_operand2 != 32'd0)
        div_result <= {div_operand1 % div_operand2, div_operand1 / div_operand2};
      else
        div_result <= 64'd0;
    end else if (dcnt != 0) begin
      dcnt       <= dcnt - 1;
      div_finish <= (dcnt == 1) && !hang;
    end
  end

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        dbz;
    int          lat;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;
  int          t0 = 0;
  int          n_assert = 0;
  int          n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    exp_t   e;
    longint sa;
    longint sb_v;
    longint q;
    longint r;
    logic [63:0] qv;
    logic [63:0] rv;
    if (b == 32'd0) begin
      e.lo = exp_lo; e.hi = exp_hi; e.dbz = 1'b1; e.lat = 1;
    end else if (sgn) begin
      sa   = longint'($signed(a));
      sb_v = longint'($signed(b));
      q    = sa / sb_v;
      r    = sa % sb_v;
      qv   = q;
      rv   = r;
      e.lo = qv[31:0]; e.hi = rv[31:0]; e.dbz = 1'b0; e.lat = 35;
    end else begin
      e.lo = a / b; e.hi = a % b; e.dbz = 1'b0; e.lat = 35;
    end
    return e;
  endfunction

  // Called at a negedge: drives the request during cycle 0, returns at the
  // negedge of cycle 1 with req_valid dropped.
  task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b, input bit push);
    bus.req_valid  = 1'b1;
    bus.req_signed = sgn;
    bus.req_a      = a;
    bus.req_b      = b;
    t0             = cyc;
    start_cnt      = 0;
    if (push) sb.push_back(model(sgn, a, b));
    @(negedge clock);
    bus.req_valid = 1'b0;
  endtask

  task automatic goto_cycle(input int rel);
    while (cyc - t0 < rel) @(negedge clock);
  endtask

  task automatic wait_done(input string tag);
    exp_t e;
    bit   seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check({tag, "_latency"}, 64'(cyc - t0), 64'(e.lat));
      check({tag, "_lo"}, 64'(bus.lo), 64'(e.lo));
      check({tag, "_hi"}, 64'(bus.hi), 64'(e.hi));
      check({tag, "_dbz"}, 64'(bus.div_by_zero), 64'(e.dbz));
      check({tag, "_no_timeout"}, 64'(bus.div_timeout), 64'd0);
      exp_lo = e.lo;
      exp_hi = e.hi;
    end
    $display("txn %s: cycle %0d lo=%h hi=%h dbz=%b", tag, cyc - t0, bus.lo, bus.hi, bus.div_by_zero);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_to;
    bit seen_done;

    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_a      = 32'd0;
    bus.req_b      = 32'd0;
    bus.wr_hi      = 1'b0;
    bus.wr_lo      = 1'b0;
    bus.wr_data    = 32'd0;
    repeat (3) @(negedge clock);
    reset = 1'b0;

    // Reset state
    check("rst_hi", 64'(bus.hi), 64'd0);
    check("rst_lo", 64'(bus.lo), 64'd0);
    check("rst_ready", 64'(bus.req_ready), 64'd1);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_outs", 64'({bus.done, bus.div_by_zero, bus.div_timeout, div_start}), 64'd0);
    check("rst_ops", {div_operand1, div_operand2}, 64'd0);

    // DIVU 100/7 with start-pulse timing
    issue(1'b0, 32'd100, 32'd7, 1'b1);
    check("divu_start_c1", 64'(div_start), 64'd1);
    check("divu_busy_c1", 64'({bus.busy, bus.req_ready}), 64'b10);
    check("divu_ops", {div_operand1, div_operand2}, {32'd100, 32'd7});
    @(negedge clock);
    check("divu_start_c2", 64'(div_start), 64'd0);
    wait_done("divu_100_7");
    check("divu_start_count", 64'(start_cnt), 64'd1);
    @(negedge clock);

    // Signed cases; stale div_finish is present at each first WAIT cycle
    issue(1'b1, 32'hFFFF_FFF9, 32'd2, 1'b1);
    check("div_neg_ops", {div_operand1, div_operand2}, {32'd7, 32'd2});
    wait_done("div_m7_2");
    @(negedge clock);
    issue(1'b1, 32'd7, 32'hFFFF_FFFE, 1'b1);
    wait_done("div_7_m2");
    @(negedge clock);
    issue(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    wait_done("div_overflow");
    @(negedge clock);

    // MTHI / MTLO in IDLE
    bus.wr_hi = 1'b1; bus.wr_data = 32'h1234_5678;
    @(negedge clock);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'hCAFE_0001;
    check("mthi", 64'(bus.hi), 64'h1234_5678);
    @(negedge clock);
    bus.wr_lo = 1'b0;
    check("mtlo", 64'(bus.lo), 64'hCAFE_0001);
    exp_hi = 32'h1234_5678;
    exp_lo = 32'hCAFE_0001;
    $display("txn mthi/mtlo: hi=%h lo=%h", bus.hi, bus.lo);

    // Zero divisor: done in cycle 1, HI/LO unchanged, no divider start
    issue(1'b0, 32'd5, 32'd0, 1'b1);
    wait_done("divu_5_0");
    check("dbz_no_start", 64'(start_cnt), 64'd0);
    @(negedge clock);

    // Request while busy is ignored; MTLO in the result-write cycle loses
    issue(1'b0, 32'd1000, 32'd10, 1'b1);
    goto_cycle(10);
    bus.req_valid = 1'b1; bus.req_signed = 1'b0; bus.req_a = 32'd77; bus.req_b = 32'd0;
    check("busy_ready_c10", 64'(bus.req_ready), 64'd0);
    @(negedge clock);
    bus.req_valid = 1'b0;
    check("busy_ignored_c11", 64'({bus.done, bus.div_by_zero, bus.busy}), 64'b001);
    goto_cycle(34);
    check("busy_not_done_c34", 64'(bus.done), 64'd0);
    bus.wr_lo = 1'b1; bus.wr_data = 32'h0000_00AB;
    @(negedge clock);
    bus.wr_lo = 1'b0;
    wait_done("divu_1000_10_wrlo");
    @(negedge clock);
    check("busy_after_idle", 64'({bus.done, bus.req_ready}), 64'b01);

    // Reset mid-divide, then an immediate new request
    issue(1'b0, 32'd50, 32'd5, 1'b0);
    goto_cycle(20);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midrst_hilo", {bus.hi, bus.lo}, 64'd0);
    check("midrst_outs", 64'({bus.done, bus.div_by_zero, bus.div_timeout, div_start, bus.busy}), 64'd0);
    check("midrst_ready", 64'(bus.req_ready), 64'd1);
    check("midrst_ops", {div_operand1, div_operand2}, 64'd0);
    $display("txn midreset: cycle %0d hi=%h lo=%h ready=%b", cyc - t0, bus.hi, bus.lo, bus.req_ready);
    exp_hi = 32'd0;
    exp_lo = 32'd0;
    issue(1'b0, 32'd9, 32'd3, 1'b1);
    wait_done("divu_9_3");
    @(negedge clock);

    // Divider that never finishes: timeout 64 cycles after START
    hang = 1'b1;
    issue(1'b0, 32'd8, 32'd2, 1'b0);
    seen_to   = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (bus.div_timeout === 1'b1) begin
        seen_to = 1'b1;
        break;
      end
      if (bus.done === 1'b1) seen_done = 1'b1;
      @(negedge clock);
    end
    check("to_seen", 64'(seen_to), 64'd1);
    check("to_cycle", 64'(cyc - t0), 64'd65);
    check("to_no_done", 64'(seen_done), 64'd0);
    check("to_ready", 64'(bus.req_ready), 64'd1);
    check("to_hilo", {bus.hi, bus.lo}, {exp_hi, exp_lo});
    $display("txn timeout: cycle %0d hi=%h lo=%h", cyc - t0, bus.hi, bus.lo);
    @(negedge clock);
    check("to_pulse_len", 64'(bus.div_timeout), 64'd0);
    hang = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/hilo_div_unit.md
HILO_DIV_UNIT -- requirements
Module: hilo_div_unit

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high, with ports named clock and reset.
REQ-002 clock  in  1  rising-edge clock for all state.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 req_valid  in  1  divide request; sampled only while req_ready=1.
REQ-005 req_signed  in  1  1 = signed DIV, 0 = unsigned DIVU.
REQ-006 req_a  in  32  dividend.
REQ-007 req_b  in  32  divisor.
REQ-008 wr_hi / wr_lo  in  1 each  MTHI / MTLO write strobes.
REQ-009 wr_data  in  32  data for wr_hi / wr_lo.
REQ-010 req_ready  out  1  high only in IDLE.
REQ-011 busy  out  1  high in START, WAIT and DONE; used as the pipeline stall.
REQ-012 hi / lo  out  32 each  architectural HI (remainder) and LO (quotient) registers.
REQ-013 done  out  1  one-cycle pulse in the first cycle that hi/lo show a new division result.
REQ-014 div_by_zero  out  1  one-cycle pulse, coincident with done, for a zero-divisor request.
REQ-015 div_timeout  out  1  one-cycle pulse when the divider fails to finish.
REQ-016 div_start  out  1  to the 32-bit unsigned divider; one-cycle start pulse.
REQ-017 div_operand1 / div_operand2  out  32 each  dividend / divisor magnitudes to the divider; held stable from START until the next accepted request.
REQ-018 div_result  in  64  from the divider: quotient in [31:0], remainder in [63:32].
REQ-019 div_finish  in  1  divider completion level.

Function
REQ-020 The FSM SHALL have states IDLE, START, WAIT and DONE, encoded in 2 bits.
REQ-021 IDLE with req_valid=1 and req_b!=0:
- register neg_q = req_signed & (a[31]^b[31]) and neg_r = req_signed & a[31];
- register div_operand1 = |a| and div_operand2 = |b|, taking the two's-complement magnitude only when req_signed=1;
- go to START.
REQ-022 IDLE with req_valid=1 and req_b==0: go to DONE with no divider start; hi and lo stay unchanged; div_by_zero=1 in that DONE cycle.
REQ-023 START SHALL assert div_start=1 for exactly one cycle, clear the 6-bit wait counter, then go to WAIT.
REQ-024 WAIT SHALL ignore div_finish in its first cycle, because div_finish may still be high from the previous operation.
REQ-025 WAIT from the second cycle onward, on div_finish=1:
- write lo = neg_q ? -div_result[31:0] : div_result[31:0];
- write hi = neg_r ? -div_result[63:32] : div_result[63:32];
- go to DONE.
REQ-026 WAIT SHALL increment the wait counter each cycle; if it reaches 63 without div_finish, pulse div_timeout for one cycle, leave hi/lo unchanged, and return to IDLE.
REQ-027 DONE SHALL assert done=1 for one cycle and return to IDLE.
REQ-028 Latency: with a request accepted in cycle 0, START is cycle 1, and against the team's 32-step divider done=1 is in cycle 35; a zero divisor gives done in cycle 1.
REQ-029 Signed overflow 0x80000000 / 0xFFFFFFFF SHALL give lo=0x80000000 and hi=0 with no special handling.
REQ-030 req_valid while busy=1 SHALL be ignored; there is no queueing.
REQ-031 wr_hi/wr_lo SHALL be accepted in any state and update hi/lo at the clock edge.
REQ-032 If wr_hi/wr_lo coincides with the WAIT->DONE result write, the division result SHALL win.
REQ-033 Signed arithmetic SHALL be pure 32-bit two's complement; remainder sign equals dividend sign; quotient truncates toward zero.

Reset
REQ-034 reset=1 SHALL force, at the next edge: state=IDLE; hi=lo=0; done=div_by_zero=div_timeout=div_start=0; div_operand1=div_operand2=0; wait counter=0.
REQ-035 Reset mid-operation SHALL abandon the division; a stale div_finish SHALL never update hi/lo, which REQ-024 guarantees for the next request.
REQ-036 reset SHALL take priority over req_valid, wr_hi and wr_lo in the same cycle.

Verification
REQ-037 DIVU a=100, b=7 -> div_start pulse in cycle 1; done in cycle 35; lo=14, hi=2.
REQ-038 DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIV a=7, b=-2 -> lo=-3, hi=1.
REQ-039 DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0; DIVU a=5, b=0 -> done and div_by_zero in cycle 1, hi/lo unchanged, div_start never asserted.
REQ-040 Second req_valid in cycle 10 of a busy divide -> ignored, req_ready=0; wr_lo=0xAB in cycle 34 (the write cycle) -> lo holds the quotient, not 0xAB.
REQ-041 Reset asserted in cycle 20 of a divide -> cycle 21 has all outputs zero and req_ready=1; a new DIVU 9/3 accepted immediately -> lo=3, hi=0.
REQ-042 Divider model that never raises div_finish -> div_timeout pulse 64 cycles after START; state returns to IDLE; hi/lo unchanged.
